jt10_adpcm_mul: RTL



---
 rtl/jt10_adpcm_mul.sv | 93 +++++++++
 1 files changed

// File: rtl/jt10_adpcm_mul.sv
// jt10_adpcm_mul
// Sequential unsigned shift-add multiply-accumulate: p = a*b + c, one bit of
// `a` consumed per clock-enable tick. Companion of jt10_adpcm_div; rebuilds a
// value from quotient, divisor and remainder without a full array multiplier.
//
// Parameters:
//   dw       operand width (4..32)
// Ports:
//   rst_n    asynchronous active-low reset
//   clk      CPU clock
//   cen      clock enable; state advances only on cen=1 edges
//   start    load operands and begin (aborts any operation in progress)
//   a, b, c  multiplier, multiplicand, addend (unsigned, sampled at start)
//   p        last completed result a*b + c (2*dw bits)
//   ovf      p does not fit in dw bits
//   working  operation in progress
//   done     high for one cen period after completion
module jt10_adpcm_mul #(
  parameter int unsigned dw = 16
) (
  input  logic            rst_n,
  input  logic            clk,
  input  logic            cen,
  input  logic            start,
  input  logic [dw-1:0]   a,
  input  logic [dw-1:0]   b,
  input  logic [dw-1:0]   c,
  output logic [2*dw-1:0] p,
  output logic            ovf,
  output logic            working,
  output logic            done
);

  logic [dw:0]     hi;
  logic [dw-1:0]   lo;
  logic [dw-1:0]   bq;
  logic [dw-1:0]   cycle;
  logic [dw-1:0]   addend;
  logic [dw:0]     s;
  logic [2*dw:0]   shifted;
  logic            last;

  assign working = cycle[0];

  // hi[dw] is always zero after a load or a shift, so adding the full hi
  // equals adding hi[dw-1:0]; the sum fits in dw+1 bits.
  always_comb begin
    addend  = lo[0] ? bq : '0;
    s       = hi + {1'b0, addend};
    shifted = {s, lo} >> 1;
    last    = (cycle == {{(dw-1){1'b0}}, 1'b1});
  end

  // Datapath registers carry no reset: they are reloaded on every start.
  always_ff @(posedge clk) begin
    if (cen) begin
      if (start) begin
        hi <= {1'b0, c};
        lo <= a;
        bq <= b;
      end else if (cycle[0]) begin
        hi <= shifted[2*dw:dw];
        lo <= shifted[dw-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle <= '0;
      p     <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else if (cen) begin
      if (start) begin
        cycle <= '1;
        done  <= 1'b0;
      end else if (cycle[0]) begin
        cycle <= cycle >> 1;
        if (last) begin
          p    <= shifted[2*dw-1:0];
          ovf  <= |shifted[2*dw-1:dw];
          done <= 1'b1;
        end else begin
          done <= 1'b0;
        end
      end else begin
        done <= 1'b0;
      end
    end
  end

endmodule
